// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes and the TAP next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR      = 4'd0,
    TAP_RTI      = 4'd1,
    TAP_SEL_DR   = 4'd2,
    TAP_CAP_DR   = 4'd3,
    TAP_SH_DR    = 4'd4,
    TAP_EX1_DR   = 4'd5,
    TAP_PAUSE_DR = 4'd6,
    TAP_EX2_DR   = 4'd7,
    TAP_UPD_DR   = 4'd8,
    TAP_SEL_IR   = 4'd9,
    TAP_CAP_IR   = 4'd10,
    TAP_SH_IR    = 4'd11,
    TAP_EX1_IR   = 4'd12,
    TAP_PAUSE_IR = 4'd13,
    TAP_EX2_IR   = 4'd14,
    TAP_UPD_IR   = 4'd15
  } tap_state_t;

  localparam logic [3:0] INSTR_IDCODE = 4'b0001;
  localparam logic [3:0] INSTR_BYPASS = 4'b1111;
  localparam logic [3:0] IR_CAPTURE   = 4'b0101;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TAP_TLR:      tap_next = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   tap_next = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   tap_next = tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_SH_DR:    tap_next = tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_EX1_DR:   tap_next = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: tap_next = tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
      TAP_EX2_DR:   tap_next = tms ? TAP_UPD_DR   : TAP_SH_DR;
      TAP_UPD_DR:   tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   tap_next = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   tap_next = tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_SH_IR:    tap_next = tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_EX1_IR:   tap_next = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: tap_next = tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
      TAP_EX2_IR:   tap_next = tms ? TAP_UPD_IR   : TAP_SH_IR;
      TAP_UPD_IR:   tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      tap_next = TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state register advanced by TMS on rising TCK; TRST forces Test-Logic-Reset.
import jtag_pkg::*;

module jtag_tap_fsm (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       tms_i,
  output tap_state_t state_o
);

  tap_state_t state_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= TAP_TLR;
    else            state_q <= tap_next(state_q, tms_i);
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller feeding a 32-bit serial transmitter: IR, BYPASS register and TDO mux.
import jtag_pkg::*;

module jtag_tap_controller #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1BEEF0CB,
  parameter int          IR_WIDTH     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic                dr_tdo,
  output logic                dr_enable,
  output logic [31:0]         dr_word,
  output logic                tdo,
  output logic                tdo_oe,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_oe_q, tdo_oe_d;
  logic                pass_q, pass_d;
  logic                is_idcode;

  jtag_tap_fsm u_fsm (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .tms_i     (tms),
    .state_o   (state)
  );

  always_comb begin
    ir_sr_d  = ir_sr_q;
    ir_d     = ir_q;
    bypass_d = bypass_q;
    case (state)
      TAP_TLR:    ir_d     = IR_IDCODE;
      TAP_CAP_IR: ir_sr_d  = IR_CAP;
      TAP_SH_IR:  ir_sr_d  = {tdi, ir_sr_q[IR_WIDTH-1:1]};
      TAP_UPD_IR: ir_d     = ir_sr_q;
      TAP_CAP_DR: bypass_d = 1'b0;
      TAP_SH_DR:  bypass_d = tdi;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_sr_q  <= IR_CAP;
      ir_q     <= IR_IDCODE;
      bypass_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      bypass_q <= bypass_d;
    end
  end

  // Test-Logic-Reset must present IDCODE immediately, not one TCK after entry.
  assign ir        = (state == TAP_TLR) ? IR_IDCODE : ir_q;
  assign is_idcode = (ir == IR_IDCODE);
  assign dr_enable = (state == TAP_SH_DR) && is_idcode;
  assign dr_word   = is_idcode ? IDCODE_VALUE : 32'd0;
  assign tap_state = state;

  always_comb begin
    tdo_d    = 1'b0;
    pass_d   = 1'b0;
    tdo_oe_d = 1'b0;
    case (state)
      TAP_SH_IR: begin
        tdo_d    = ir_sr_q[0];
        tdo_oe_d = 1'b1;
      end
      TAP_SH_DR: begin
        tdo_oe_d = 1'b1;
        if (is_idcode) pass_d = 1'b1;
        else           tdo_d  = bypass_q;
      end
      default: ;
    endcase
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
      pass_q   <= pass_d;
    end
  end

  // Transmitter output is already falling-edge registered, so it bypasses tdo_q.
  assign tdo    = pass_q ? dr_tdo : tdo_q;
  assign tdo_oe = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Randomized TAP bench: table-driven reference model feeds a per-cycle scoreboard checked by a monitor.
module tb_jtag_tap_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        dr_tdo;
  logic        dr_enable;
  logic [31:0] dr_word;
  logic        tdo;
  logic        tdo_oe;
  logic [3:0]  tap_state;
  logic [3:0]  ir;

  int tests = 0;
  int fails = 0;

  jtag_tap_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tms       (tms),
    .tdi       (tdi),
    .dr_tdo    (dr_tdo),
    .dr_enable (dr_enable),
    .dr_word   (dr_word),
    .tdo       (tdo),
    .tdo_oe    (tdo_oe),
    .tap_state (tap_state),
    .ir        (ir)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream 32-bit transmitter: MSB first, restarts when enable drops.
  logic [4:0] tx_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)       tx_cnt <= 5'd0;
    else if (dr_enable) tx_cnt <= tx_cnt + 5'd1;
    else                tx_cnt <= 5'd0;
  end
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) dr_tdo <= 1'b0;
    else          dr_tdo <= dr_enable ? dr_word[5'd31 - tx_cnt] : 1'b0;
  end

  // Reference model: transition table written straight from the state diagram.
  int nxt [16][2] = '{'{1,0}, '{1,2}, '{3,9}, '{4,5}, '{4,5}, '{6,8}, '{6,7}, '{4,8},
                      '{1,2}, '{10,0}, '{11,12}, '{11,12}, '{13,15}, '{13,14}, '{11,15}, '{1,2}};
  logic [31:0] idc = 32'h1BEEF0CB;
  int m_state, m_ir, m_irsr, m_byp, m_cnt;

  typedef struct {
    int          st;
    int          irv;
    bit          tdo;
    bit          oe;
    bit          en;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  bit   cap_q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_ir = 1; m_irsr = 5; m_byp = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input bit t, input bit d);
    int old;
    old = m_state;
    if (old == 4 && m_ir == 1) m_cnt = (m_cnt + 1) % 32;
    else                       m_cnt = 0;
    if (old == 3)      m_byp = 0;
    else if (old == 4) m_byp = int'(d);
    if (old == 15) m_ir = m_irsr;
    if (old == 10)      m_irsr = 5;
    else if (old == 11) m_irsr = (m_irsr >> 1) | (int'(d) << 3);
    m_state = nxt[old][t];
    if (m_state == 0) m_ir = 1;
  endfunction

  function automatic exp_t expected();
    exp_t e;
    e.st   = m_state;
    e.irv  = m_ir;
    e.oe   = (m_state == 4) || (m_state == 11);
    e.en   = (m_state == 4) && (m_ir == 1);
    e.word = (m_ir == 1) ? idc : 32'd0;
    if (m_state == 11)     e.tdo = m_irsr[0];
    else if (m_state == 4) e.tdo = (m_ir == 1) ? idc[31 - m_cnt] : m_byp[0];
    else                   e.tdo = 1'b0;
    return e;
  endfunction

  // Monitor: every cycle with a pending expectation, compare the DUT mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", 32'(tap_state), e.st);
        chk("ir", 32'(ir), e.irv);
        chk("tdo", 32'(tdo), 32'(e.tdo));
        chk("tdo_oe", 32'(tdo_oe), 32'(e.oe));
        chk("dr_enable", 32'(dr_enable), 32'(e.en));
        chk("dr_word", dr_word, e.word);
        if (tdo_oe === 1'b1) cap_q.push_back(tdo);
      end
    end
  end

  task automatic tick(input bit t, input bit d);
    tms = t;
    tdi = d;
    @(posedge clk);
    #1;
    model_edge(t, d);
    exp_q.push_back(expected());
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, 32'(tap_state), 0);
    chk({tag, "_ir"}, 32'(ir), 1);
    chk({tag, "_tdo"}, 32'(tdo), 0);
    chk({tag, "_tdo_oe"}, 32'(tdo_oe), 0);
    chk({tag, "_dr_enable"}, 32'(dr_enable), 0);
    chk({tag, "_dr_word"}, dr_word, 32'h1BEEF0CB);
  endtask

  // Assert TRST between edges, check outputs before any clock edge, then release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    tms = 1'b1;
    #1;
    reset_checks(tag);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] cap_bits(input bit msb_first);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < cap_q.size() && i < 32; i++) begin
      if (msb_first) v = {v[30:0], cap_q[i]};
      else           v[i] = cap_q[i];
    end
    return v;
  endfunction

  // From any state: IR path, shift v LSB first, update, finish in Select-DR-Scan.
  task automatic load_ir(input logic [3:0] v);
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    cap_q.delete();
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
    chk("ir_capture_len", cap_q.size(), 4);
    chk("ir_capture_bits", cap_bits(1'b0), 32'h5);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("ir_update", 32'(ir), 32'(v));
  endtask

  // From Select-DR-Scan: n Shift-DR cycles shifting pat LSB first; expects bypass behaviour.
  task automatic shift_dr_bypass(input logic [7:0] pat, input int n);
    logic [31:0] req = 32'd0;
    tick(1'b0, 1'b0);
    cap_q.delete();
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick(i == n - 1, pat[i]);
    for (int k = 1; k < n; k++) req[k] = pat[k-1];
    chk("bypass_len", cap_q.size(), n);
    chk("bypass_stream", cap_bits(1'b0), req);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  initial begin
    int steps;
    model_reset();
    #2;
    reset_checks("por");
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    // Five TMS=1 edges reach Test-Logic-Reset from every state.
    for (int s = 0; s < 16; s++) begin
      steps = 0;
      while (m_state != s && steps < 300) begin
        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        steps++;
      end
      chk("reach_state", 32'(tap_state), s);
      repeat (5) tick(1'b1, 1'($urandom_range(0, 1)));
      chk("tms5_to_tlr", 32'(tap_state), 0);
    end

    // IDCODE shifted out through the transmitter.
    do_reset("rst_a");
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    cap_q.delete();
    tick(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) tick(i == 31, 1'($urandom_range(0, 1)));
    chk("idcode_len", cap_q.size(), 32);
    chk("idcode_stream", cap_bits(1'b1), 32'h1BEEF0CB);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // BYPASS: TDI 1,0,1,1 seen one cycle late after a leading capture 0.
    load_ir(4'b1111);
    shift_dr_bypass(8'b0000_1101, 5);

    // Undefined opcode behaves as BYPASS with a zero word.
    load_ir(4'b0110);
    chk("undef_dr_word", dr_word, 32'd0);
    shift_dr_bypass(8'($urandom), 8);

    // TRST mid-shift in bypass mode with a 1 on TDO.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    do_reset("rst_byp");

    // TRST mid-shift while IDCODE streams.
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b0);
    do_reset("rst_idc");

    // Free-running random traffic.
    for (int i = 0; i < 600; i++)
      tick(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

IEEE 1149.1 test access port controller that sits directly upstream of the 32-bit `byte_transmitter`. Tracks the 16-state TAP FSM from TMS, holds a 4-bit instruction register and a 1-bit BYPASS register, and supplies the transmitter with its `enable` and 32-bit `in` word. Multiplexes the final TDO from the IR, BYPASS, or the transmitter's output.

## Interface
- `IDCODE_VALUE`, 32'h1BEEF0CB, word presented on `dr_word` under IDCODE (bit 0 must be 1)
- `IR_WIDTH`, 4, instruction register width
- `clk` input 1: TCK; all state on rising edge except TDO-path flops (falling edge)
- `reset_n` input 1: asynchronous, active-low (TRST); forces Test-Logic-Reset
- `tms` input 1: test mode select, sampled on rising `clk`
- `tdi` input 1: test data in, sampled on rising `clk`
- `dr_tdo` input 1: `out` of downstream transmitter
- `dr_enable` output 1: to transmitter `enable`
- `dr_word` output 32: to transmitter `in`
- `tdo` output 1: test data out
- `tdo_oe` output 1: high in Shift-IR or Shift-DR
- `tap_state` output 4: current FSM state (package encoding)
- `ir` output IR_WIDTH: current instruction

## Operation
- FSM (TMS=0 / TMS=1): TLR→RTI/TLR; RTI→RTI/SelDR; SelDR→CapDR/SelIR; CapDR→ShDR/Ex1DR; ShDR→ShDR/Ex1DR; Ex1DR→PauseDR/UpdDR; PauseDR→PauseDR/Ex2DR; Ex2DR→ShDR/UpdDR; UpdDR→RTI/SelDR; SelIR→CapIR/TLR; IR branch mirrors DR branch; UpdIR→RTI/SelDR.
- Instructions: 4'b0001 IDCODE, 4'b1111 BYPASS; any other opcode behaves as BYPASS.
- IR: shift register `ir_sr`; Capture-IR loads 4'b0101; Shift-IR shifts right, `tdi` into MSB; Update-IR copies `ir_sr` to `ir`. In TLR, `ir` = IDCODE.
- BYPASS reg: Capture-DR loads 0; Shift-DR loads `tdi`.
- `dr_enable` = (state==ShDR) && (ir==IDCODE); combinational from registered state. It drops in Ex1DR/PauseDR, so the transmitter restarts its 32-bit count on re-entry to ShDR. This is accepted, not compensated.
- `dr_word` = `IDCODE_VALUE` when ir==IDCODE, else 0.
- TDO select (registered on falling `clk`): ShIR → `ir_sr[0]`; ShDR & BYPASS → bypass reg; ShDR & IDCODE → `dr_tdo` passes combinationally, since it is already negedge-registered downstream; otherwise 0.
- `tdo_oe` follows state, updated on falling `clk` alongside TDO.

## Timing
- Reset values: state=TLR (`tap_state`=0), `ir`=IDCODE, `ir_sr`=0101, bypass=0, `tdo`=0, `tdo_oe`=0, `dr_enable`=0, `dr_word`=IDCODE_VALUE.
- `reset_n` asserted mid-shift: all of the above take effect immediately. This applies to the negedge flops too. No partial IR update.
- Five consecutive rising edges with TMS=1 reach TLR from any state.
- State changes one rising edge after the TMS sample. Outputs decoded from state are valid the same cycle.
- IR bit n appears on `tdo` from the falling edge of the nth ShIR cycle and is sampled by the host on the next rising edge.
- BYPASS: one-cycle TDI→TDO delay, with a leading 0 from capture.

## Structure
- Package `jtag_pkg` holds:
  - `tap_state_t` (4-bit enum, TLR=0 … UpdIR=15)
  - opcode constants `INSTR_IDCODE` and `INSTR_BYPASS`
  - IR capture constant 4'b0101
- Sub-module `jtag_tap_fsm` contains the next-state logic and state register only. The top level holds the IR, BYPASS, and TDO mux.

## Test plan
- Assert `reset_n`=0 mid-ShDR → state=TLR, `ir`=0001, `tdo`=0, `tdo_oe`=0 immediately, without waiting for a clock edge.
- From RTI, TMS=1,1,1,1,1 → TLR after the 5th edge. Repeat starting from each of the 16 states.
- Reset, then TMS path to ShDR, hold 32 cycles with the transmitter attached → `tdo` stream MSB-first equals 32'h1BEEF0CB; `dr_enable` high exactly during ShDR.
- Enter ShIR and shift TDI=1,1,1,1 → `tdo` shows 1,0,1,0 (capture 0101, LSB first). After Update-IR, `ir`=1111.
- BYPASS loaded, ShDR with TDI pattern 1,0,1,1 → `tdo` = 0,1,0,1,1 (one-cycle delay); `dr_enable` stays 0.
- Load IR=4'b0110 (undefined opcode) → DR shift behaves as BYPASS; `dr_word`=0.
